fwd_scoreboard: RTL and testbench

Parametrised forwarding and hazard unit for the pipelined core. It records the destinations of in-flight instructions after EXE in a DEPTH-entry history shift register, so the pipeline does not have to present per-stage destinations. From that history it produces per-source bypass selects for the EXE stage, a load-use stall request for the ID stage, and a saturating hazard-cycle counter. FWD_EN=0 gives a stall-only mode for bring-up builds.

---
 rtl/fwd_scoreboard.sv | 124 ++++++++++++
 tb/tb_fwd_scoreboard.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fwd_scoreboard.sv
// Forwarding / hazard unit: keeps a DEPTH-slot history of post-EXE writers and
// derives EXE bypass selects, the ID load-use stall and a saturating stall counter.
module fwd_scoreboard #(
  parameter  int REG_W   = 4,
  parameter  int NUM_SRC = 3,
  parameter  int DEPTH   = 2,
  parameter  int FWD_EN  = 1,
  parameter  int CNT_W   = 16,
  localparam int SEL_W   = $clog2(DEPTH + 1)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       adv,
  input  logic                       flush,
  input  logic                       exe_valid,
  input  logic                       exe_wb_en,
  input  logic                       exe_mem_read,
  input  logic [REG_W-1:0]           exe_dest,
  input  logic [NUM_SRC*REG_W-1:0]   exe_src,
  input  logic [NUM_SRC-1:0]         exe_src_vld,
  input  logic [NUM_SRC*REG_W-1:0]   id_src,
  input  logic [NUM_SRC-1:0]         id_src_vld,
  output logic [NUM_SRC*SEL_W-1:0]   sel,
  output logic                       hazard,
  output logic [CNT_W-1:0]           hazard_cnt
);

  localparam logic [DEPTH-1:0] MEM_SLOT = DEPTH'(1);

  logic [DEPTH-1:0]                  r_vld;
  logic [DEPTH-1:0]                  r_ld;
  logic [REG_W-1:0]                  r_dest [DEPTH];
  logic [CNT_W-1:0]                  r_cnt;

  logic                              w_cap_vld;
  logic                              w_ex_wr;
  logic                              w_haz;
  logic [NUM_SRC-1:0][DEPTH-1:0]     w_hit;
  logic [NUM_SRC-1:0][SEL_W-1:0]     w_sel;
  logic [NUM_SRC-1:0]                w_ld_fwd;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  assign w_cap_vld = exe_valid & exe_wb_en & ~flush;
  assign w_ex_wr   = exe_valid & exe_wb_en;

  // History capture: slot 0 = MEM, shifting older on every advance
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld <= '0;
    end else if (adv) begin
      r_vld <= {r_vld[DEPTH-2:0], w_cap_vld};
    end
  end

  always_ff @(posedge clk) begin
    if (adv) begin
      r_ld      <= {r_ld[DEPTH-2:0], exe_mem_read};
      r_dest[0] <= exe_dest;
      for (int k = 1; k < DEPTH; k++) begin
        r_dest[k] <= r_dest[k-1];
      end
    end
  end

  // Bypass select: scanning oldest-to-youngest lets the youngest hit win
  always_comb begin
    w_hit    = '0;
    w_sel    = '0;
    w_ld_fwd = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      for (int k = 0; k < DEPTH; k++) begin
        w_hit[i][k] = exe_src_vld[i] & r_vld[k] &
                      (r_dest[k] == exe_src[i*REG_W +: REG_W]);
      end
      for (int k = DEPTH - 1; k >= 0; k--) begin
        if (w_hit[i][k]) begin
          w_sel[i] = SEL_W'(k + 1);
        end
      end
      w_ld_fwd[i] = |(w_hit[i] & r_ld & MEM_SLOT);
    end
  end

  assign sel = (rst || (FWD_EN == 0)) ? '0 : w_sel;

  // Stall detect; the oldest slot retires through a write-first regfile
  always_comb begin
    w_haz = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (id_src_vld[i] && w_ex_wr && (id_src[i*REG_W +: REG_W] == exe_dest)) begin
        if ((FWD_EN == 0) || exe_mem_read) begin
          w_haz = 1'b1;
        end
      end
      if (FWD_EN == 0) begin
        for (int k = 0; k < DEPTH - 1; k++) begin
          if (id_src_vld[i] && r_vld[k] && (r_dest[k] == id_src[i*REG_W +: REG_W])) begin
            w_haz = 1'b1;
          end
        end
      end
    end
  end

  assign hazard = ~rst & w_haz;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (hazard) begin
      r_cnt <= sat_inc(r_cnt);
    end
  end

  assign hazard_cnt = r_cnt;

  // Load data is not ready in MEM; the ID load-use stall must keep this from happening
  a_no_mem_load_bypass: assert property (@(posedge clk) disable iff (rst)
    (FWD_EN == 0) || (w_ld_fwd == '0));

endmodule

// File: tb/tb_fwd_scoreboard.sv
// Directed bench: a forwarding instance (DEPTH=2, CNT_W=4) and a stall-only
// instance (DEPTH=3) share one stimulus stream.
module tb_fwd_scoreboard;

  logic        clk;
  logic        rst;
  logic        adv;
  logic        flush;
  logic        exe_valid;
  logic        exe_wb_en;
  logic        exe_mem_read;
  logic [3:0]  exe_dest;
  logic [11:0] exe_src;
  logic [2:0]  exe_src_vld;
  logic [11:0] id_src;
  logic [2:0]  id_src_vld;
  logic [5:0]  sel_a;
  logic [5:0]  sel_b;
  logic        hazard_a;
  logic        hazard_b;
  logic [3:0]  cnt_a;
  logic [15:0] cnt_b;

  int n_tests = 0;
  int n_fail  = 0;

  fwd_scoreboard #(.REG_W(4), .NUM_SRC(3), .DEPTH(2), .FWD_EN(1), .CNT_W(4)) u_fwd (
    .clk(clk), .rst(rst), .adv(adv), .flush(flush),
    .exe_valid(exe_valid), .exe_wb_en(exe_wb_en), .exe_mem_read(exe_mem_read),
    .exe_dest(exe_dest), .exe_src(exe_src), .exe_src_vld(exe_src_vld),
    .id_src(id_src), .id_src_vld(id_src_vld),
    .sel(sel_a), .hazard(hazard_a), .hazard_cnt(cnt_a)
  );

  fwd_scoreboard #(.REG_W(4), .NUM_SRC(3), .DEPTH(3), .FWD_EN(0), .CNT_W(16)) u_stall (
    .clk(clk), .rst(rst), .adv(adv), .flush(flush),
    .exe_valid(exe_valid), .exe_wb_en(exe_wb_en), .exe_mem_read(exe_mem_read),
    .exe_dest(exe_dest), .exe_src(exe_src), .exe_src_vld(exe_src_vld),
    .id_src(id_src), .id_src_vld(id_src_vld),
    .sel(sel_b), .hazard(hazard_b), .hazard_cnt(cnt_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [1:0] sa(input int i);
    return sel_a[i*2 +: 2];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    adv          = 1'b1;
    flush        = 1'b0;
    exe_valid    = 1'b0;
    exe_wb_en    = 1'b0;
    exe_mem_read = 1'b0;
    exe_dest     = 4'd0;
    exe_src      = '0;
    exe_src_vld  = '0;
    id_src       = '0;
    id_src_vld   = '0;
  endtask

  task automatic exe_wr(input logic [3:0] d, input logic ld);
    exe_valid    = 1'b1;
    exe_wb_en    = 1'b1;
    exe_mem_read = ld;
    exe_dest     = d;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    #2;
    chk("rst_sel", sel_a, 0);
    chk("rst_haz", hazard_a, 0);
    chk("rst_cnt_a", cnt_a, 0);
    chk("rst_cnt_b", cnt_b, 0);
    tick();
    tick();
    rst = 1'b0;

    // Back-to-back ALU writes to r3: youngest wins, then ages to WB
    exe_wr(4'd3, 1'b0);
    tick();
    tick();
    exe_valid   = 1'b0;
    exe_src     = 12'h003;
    exe_src_vld = 3'b001;
    #1;
    chk("b2b_youngest", sa(0), 1);
    tick();
    chk("b2b_aged", sa(0), 2);
    tick();
    chk("b2b_gone", sa(0), 0);

    // Load-use on source 1
    idle();
    adv = 1'b0;
    exe_wr(4'd5, 1'b1);
    id_src     = 12'h050;
    id_src_vld = 3'b010;
    #1;
    chk("lu_haz", hazard_a, 1);
    chk("lu_cnt0", cnt_a, 0);
    tick();
    chk("lu_cnt1", cnt_a, 1);
    id_src_vld = 3'b000;
    #1;
    chk("lu_unused", hazard_a, 0);
    tick();
    chk("lu_cnt_hold", cnt_a, 1);
    exe_mem_read = 1'b0;
    id_src_vld   = 3'b010;
    #1;
    chk("alu_no_stall", hazard_a, 0);
    chk("alu_stall_only", hazard_b, 1);

    // Freeze with r7 in MEM, then a flushed writer to r9
    idle();
    exe_wr(4'd7, 1'b0);
    tick();
    adv = 1'b0;
    exe_wr(4'd8, 1'b0);
    exe_src     = 12'h087;
    exe_src_vld = 3'b011;
    #1;
    for (int c = 0; c < 3; c++) begin
      chk("frz_r7", sa(0), 1);
      chk("frz_r8", sa(1), 0);
      tick();
    end
    chk("frz_r7_end", sa(0), 1);
    adv   = 1'b1;
    flush = 1'b1;
    exe_wr(4'd9, 1'b0);
    exe_src     = 12'h987;
    exe_src_vld = 3'b111;
    #1;
    chk("fl_pre", sa(2), 0);
    tick();
    chk("fl_r9", sa(2), 0);
    chk("fl_r7_wb", sa(0), 2);
    flush     = 1'b0;
    exe_valid = 1'b0;
    tick();
    chk("fl_r9_late", sa(2), 0);
    chk("fl_r7_gone", sa(0), 0);

    // Stall-only build: r2 in slot 1 stalls, in the last slot it does not
    rst = 1'b1;
    #1;
    rst = 1'b0;
    idle();
    exe_wr(4'd2, 1'b0);
    tick();
    exe_valid = 1'b0;
    tick();
    exe_src     = 12'h002;
    exe_src_vld = 3'b001;
    id_src      = 12'h002;
    id_src_vld  = 3'b001;
    #1;
    chk("s0_slot1_haz", hazard_b, 1);
    chk("s0_sel_zero", sel_b, 0);
    chk("fwd_no_haz", hazard_a, 0);
    chk("fwd_sel_wb", sa(0), 2);
    tick();
    chk("s0_slot2_nohaz", hazard_b, 0);
    chk("s0_cnt1", cnt_b, 1);
    adv = 1'b0;
    exe_wr(4'd2, 1'b0);
    #1;
    chk("s0_exe_haz", hazard_b, 1);
    tick();
    chk("s0_cnt2", cnt_b, 2);

    // Counter saturation at 15
    rst = 1'b1;
    #1;
    rst = 1'b0;
    idle();
    adv = 1'b0;
    exe_wr(4'd5, 1'b1);
    id_src     = 12'h050;
    id_src_vld = 3'b010;
    #1;
    repeat (14) tick();
    chk("sat_14", cnt_a, 14);
    tick();
    chk("sat_15", cnt_a, 15);
    repeat (5) tick();
    chk("sat_hold", cnt_a, 15);

    // Asynchronous reset mid-cycle drops history and counter
    adv = 1'b1;
    exe_wr(4'd7, 1'b0);
    tick();
    adv = 1'b0;
    exe_wr(4'd5, 1'b1);
    exe_src     = 12'h007;
    exe_src_vld = 3'b001;
    #1;
    chk("pre_rst_sel", sa(0), 1);
    chk("pre_rst_haz", hazard_a, 1);
    chk("pre_rst_cnt", cnt_a, 15);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_cnt", cnt_a, 0);
    chk("arst_sel", sel_a, 0);
    chk("arst_haz", hazard_a, 0);
    chk("arst_haz_b", hazard_b, 0);
    #1;
    rst = 1'b0;
    #1;
    chk("post_rst_sel", sa(0), 0);
    chk("post_rst_haz", hazard_a, 1);
    tick();
    chk("post_rst_cnt", cnt_a, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
